hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised ID-stage hazard detector for the 5-stage MIPS pipeline. Replaces the fixed
//  load-use/branch compare logic with a shift-register scoreboard of in-flight register writes,
//  each carrying a countdown until its result is forwardable. Adds a multi-cycle MUL/DIV busy
//  counter that guards HI/LO. Drives DataHazard (stall PC/IF-ID, bubble ID/EX) and ControlHazard.
// PARAMETERS
//  ADDR_W     5   register address width
//  DEPTH      3   scoreboard entries (stages after ID that may still hold a pending write), >=2
//  ALU_LAT    1   countdown loaded for non-load writers
//  LOAD_LAT   2   countdown loaded for loads (MemRead); must be >= ALU_LAT and < 2^CNT_W
//  MD_CYCLES  32  MUL/DIV occupancy in cycles, >=1
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       asynchronous, active-low
//  pipe_hold       in   1       global freeze (memory wait); scoreboard holds
//  id_valid        in   1       real instruction in IF/ID
//  id_rs_addr      in   ADDR_W  source rs
//  id_rt_addr      in   ADDR_W  source rt
//  id_PCSrc        in   2       01 j/jal, 10 jr/jalr, else sequential
//  id_Branch       in   1       conditional branch (compares in ID)
//  id_Equal        in   1       branch condition true
//  id_RegWrite     in   1       instruction writes a GPR
//  id_MemRead      in   1       instruction is a load
//  id_write_addr   in   ADDR_W  destination GPR
//  id_MulDiv       in   1       starts a MUL/DIV
//  id_HiLoRead     in   1       mfhi/mflo
//  DataHazard      out  1       stall IF/PC, insert bubble into ID/EX
//  ControlHazard   out  1       flush IF/ID
//  md_busy         out  1       MUL/DIV in progress
// BEHAVIOUR
//  - Entry k = {v, addr, cnt}; k=0 is the ID/EX slot. CNT_W = clog2(LOAD_LAT+1).
//  - Reset: all v=0, cnt=0, md counter=0 -> DataHazard=0, md_busy=0; ControlHazard follows inputs.
//  - issue = id_valid & ~DataHazard & ~pipe_hold.
//  - Each edge with pipe_hold=0: entry k+1 <= entry k with cnt-1 (saturating at 0); last entry
//    is dropped. Entry 0 <= {1, id_write_addr, MemRead?LOAD_LAT:ALU_LAT} if issue & RegWrite
//    & write_addr!=0, else v=0 (bubble). pipe_hold=1: all entries unchanged.
//  - match_k = v_k & addr_k!=0 & (addr_k==rs | addr_k==rt).
//  - ID consumer (Branch or PCSrc==10): hazard if any match_k with cnt_k>0.
//    All others (EX consumer): hazard if any match_k with cnt_k>1.
//  - Defaults reproduce legacy rules: load in ID/EX stalls all; ALU in ID/EX stalls only
//    branch/jr; load in EX/MEM stalls only branch/jr.
//  - MUL/DIV: on issue & id_MulDiv, counter <= MD_CYCLES; else decrements to 0 every cycle
//    (independent of pipe_hold). md_busy = counter!=0. Hazard if (id_MulDiv|id_HiLoRead) & md_busy.
//  - DataHazard = id_valid & (gpr hazard | md hazard); combinational from state + ID inputs.
//  - ControlHazard = id_valid & (PCSrc==01 | (~DataHazard & (PCSrc==10 | Branch&Equal))).
//  - Duplicate destinations across entries all tracked; hazard is OR over entries.
//  - Reset asserted mid-operation clears scoreboard and MD counter immediately.
// STRUCTURE
//  - Shared package/header: PCSrc encodings (PC_SEQ, PC_J, PC_JR), ADDR_W, default latencies.
//  - One sub-module: hazard_sb_entry (one scoreboard slot: shift/hold/decrement, match compare),
//    instantiated DEPTH times via generate; MD counter and output logic in top.
// TESTING
//  - lw $8 issued; next ID add rs=$8 -> DataHazard=1 one cycle, then 0; ID/EX bubble.
//  - add $9 issued; next ID beq rs=$9 -> DataHazard=1 one cycle; with add-use instead -> 0.
//  - lw $10, nop, then beq rt=$10 -> DataHazard=1 exactly one cycle.
//  - dest $0 on load then use of $0 -> DataHazard=0.
//  - j with any hazard -> ControlHazard=1; beq Equal=1 stalled -> ControlHazard=0 until stall clears.
//  - mult then mflo -> DataHazard held MD_CYCLES cycles; pipe_hold=1 for 3 cycles after lw:
//    scoreboard frozen, hazard persists; reset pulse mid-run -> DataHazard=0, md_busy=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: PC source
// encodings and default pipeline latencies.
package hazard_scoreboard_pkg;

  localparam int unsigned ADDR_W_DEF    = 5;
  localparam int unsigned DEPTH_DEF     = 3;
  localparam int unsigned ALU_LAT_DEF   = 1;
  localparam int unsigned LOAD_LAT_DEF  = 2;
  localparam int unsigned MD_CYCLES_DEF = 32;

  // Next-PC selection as decoded in ID; 2'b11 behaves as sequential.
  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_J       = 2'b01,
    PC_JR      = 2'b10,
    PC_SEQ_ALT = 2'b11
  } pc_src_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle between the decode logic (master) and the hazard
// scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              pipe_hold;
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [1:0]        id_PCSrc;
  logic              id_Branch;
  logic              id_Equal;
  logic              id_RegWrite;
  logic              id_MemRead;
  logic [ADDR_W-1:0] id_write_addr;
  logic              id_MulDiv;
  logic              id_HiLoRead;
  logic              DataHazard;
  logic              ControlHazard;
  logic              md_busy;

  modport master (
    output pipe_hold, id_valid, id_rs_addr, id_rt_addr, id_PCSrc, id_Branch,
           id_Equal, id_RegWrite, id_MemRead, id_write_addr, id_MulDiv,
           id_HiLoRead,
    input  DataHazard, ControlHazard, md_busy
  );

  modport slave (
    input  pipe_hold, id_valid, id_rs_addr, id_rt_addr, id_PCSrc, id_Branch,
           id_Equal, id_RegWrite, id_MemRead, id_write_addr, id_MulDiv,
           id_HiLoRead,
    output DataHazard, ControlHazard, md_busy
  );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: holds a pending GPR write and its countdown until
// the result becomes forwardable, and compares it against the ID sources.
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              in_v,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              v,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  cnt_next,
  output logic              hz_id,
  output logic              hz_ex
);

  logic [CNT_W-1:0] cnt;
  logic             match;

  // Slot register: capture the upstream slot unless the pipeline is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v    <= 1'b0;
      addr <= '0;
      cnt  <= '0;
    end else if (!hold) begin
      v    <= in_v;
      addr <= in_addr;
      cnt  <= in_cnt;
    end
  end

  // Source compare and the saturating countdown handed to the next slot.
  always_comb begin
    cnt_next = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    match    = v && (addr != '0) && ((addr == rs_addr) || (addr == rt_addr));
    hz_id    = match && (cnt != '0);
    hz_ex    = match && (cnt > CNT_W'(1));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detector: shift-register scoreboard of in-flight GPR
// writes plus a MUL/DIV occupancy counter guarding HI/LO.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned ALU_LAT   = ALU_LAT_DEF,
  parameter int unsigned LOAD_LAT  = LOAD_LAT_DEF,
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int unsigned CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int unsigned MD_W  = $clog2(MD_CYCLES + 1);

  logic              ent_v        [DEPTH];
  logic [ADDR_W-1:0] ent_addr     [DEPTH];
  logic [CNT_W-1:0]  ent_cnt_next [DEPTH];
  logic              ent_hz_id    [DEPTH];
  logic              ent_hz_ex    [DEPTH];
  logic              in_v         [DEPTH];
  logic [ADDR_W-1:0] in_addr      [DEPTH];
  logic [CNT_W-1:0]  in_cnt       [DEPTH];

  logic             issue;
  logic             new_v;
  logic             id_consumer;
  logic             any_hz_id;
  logic             any_hz_ex;
  logic             gpr_hz;
  logic             md_hz;
  logic             busy;
  logic             data_hazard;
  logic [MD_W-1:0]  md_cnt;

  // Slot 0 takes the issuing writer (or a bubble); slot k takes slot k-1.
  always_comb begin
    new_v      = issue && bus.id_RegWrite && (bus.id_write_addr != '0);
    in_v[0]    = new_v;
    in_addr[0] = new_v ? bus.id_write_addr : '0;
    in_cnt[0]  = !new_v          ? '0 :
                 bus.id_MemRead  ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    for (int unsigned k = 1; k < DEPTH; k++) begin
      in_v[k]    = ent_v[k-1];
      in_addr[k] = ent_addr[k-1];
      in_cnt[k]  = ent_cnt_next[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_entry
    hazard_sb_entry #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .hold     (bus.pipe_hold),
      .in_v     (in_v[k]),
      .in_addr  (in_addr[k]),
      .in_cnt   (in_cnt[k]),
      .rs_addr  (bus.id_rs_addr),
      .rt_addr  (bus.id_rt_addr),
      .v        (ent_v[k]),
      .addr     (ent_addr[k]),
      .cnt_next (ent_cnt_next[k]),
      .hz_id    (ent_hz_id[k]),
      .hz_ex    (ent_hz_ex[k])
    );
  end

  // Hazard decision: branches/jr consume in ID, everything else in EX.
  always_comb begin
    any_hz_id = 1'b0;
    any_hz_ex = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      any_hz_id = any_hz_id | ent_hz_id[k];
      any_hz_ex = any_hz_ex | ent_hz_ex[k];
    end
    id_consumer = bus.id_Branch || (pc_src_e'(bus.id_PCSrc) == PC_JR);
    gpr_hz      = id_consumer ? any_hz_id : any_hz_ex;
    busy        = (md_cnt != '0);
    md_hz       = (bus.id_MulDiv || bus.id_HiLoRead) && busy;
    data_hazard = bus.id_valid && (gpr_hz || md_hz);
    issue       = bus.id_valid && !data_hazard && !bus.pipe_hold;
    bus.DataHazard    = data_hazard;
    bus.md_busy       = busy;
    bus.ControlHazard = bus.id_valid &&
                        ((pc_src_e'(bus.id_PCSrc) == PC_J) ||
                         (!data_hazard &&
                          ((pc_src_e'(bus.id_PCSrc) == PC_JR) ||
                           (bus.id_Branch && bus.id_Equal))));
  end

  // MUL/DIV occupancy: free-running countdown, not affected by pipe_hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (issue && bus.id_MulDiv) begin
      md_cnt <= MD_W'(MD_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed per-cycle table, hand-written
// multi-cycle sequences, then random stimulus against a reference model
// that tracks in-flight writes by issue time.
module tb_hazard_scoreboard;

  localparam int DEPTH     = 3;
  localparam int ALU_LAT   = 1;
  localparam int LOAD_LAT  = 2;
  localparam int MD_CYCLES = 32;

  typedef struct {
    logic       hold, valid;
    logic [4:0] rs, rt, wa;
    logic [1:0] pc;
    logic       br, eq, rw, mr, md, hl;
  } stim_t;

  typedef struct {
    string name;
    stim_t s;
    logic  dh, ch, busy;
  } vec_t;

  typedef struct {
    logic [4:0] addr;
    int         lat;
    int         born;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  wr_t  wr_q[$];
  int   tick = 0;
  int   md_rem = 0;

  hazard_scoreboard_if #(.ADDR_W(5)) bus ();

  hazard_scoreboard #(
    .ADDR_W    (5),
    .DEPTH     (DEPTH),
    .ALU_LAT   (ALU_LAT),
    .LOAD_LAT  (LOAD_LAT),
    .MD_CYCLES (MD_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus builders ----------------
  function automatic stim_t f_idle();
    stim_t s;
    s.hold = 0; s.valid = 0; s.rs = 0; s.rt = 0; s.wa = 0; s.pc = 2'b00;
    s.br = 0; s.eq = 0; s.rw = 0; s.mr = 0; s.md = 0; s.hl = 0;
    return s;
  endfunction
  function automatic stim_t f_nop();
    stim_t s = f_idle(); s.valid = 1; return s;
  endfunction
  function automatic stim_t f_alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    stim_t s = f_nop(); s.rw = 1; s.wa = rd; s.rs = rs; s.rt = rt; return s;
  endfunction
  function automatic stim_t f_lw(logic [4:0] rd, logic [4:0] rs);
    stim_t s = f_alu(rd, rs, 5'd0); s.mr = 1; return s;
  endfunction
  function automatic stim_t f_beq(logic [4:0] rs, logic [4:0] rt, logic eq);
    stim_t s = f_nop(); s.br = 1; s.eq = eq; s.rs = rs; s.rt = rt; return s;
  endfunction
  function automatic stim_t f_j(logic [4:0] rs);
    stim_t s = f_nop(); s.pc = 2'b01; s.rs = rs; return s;
  endfunction
  function automatic stim_t f_jr(logic [4:0] rs);
    stim_t s = f_nop(); s.pc = 2'b10; s.rs = rs; return s;
  endfunction
  function automatic stim_t f_mult();
    stim_t s = f_nop(); s.md = 1; s.rs = 5'd20; s.rt = 5'd21; return s;
  endfunction
  function automatic stim_t f_mflo();
    stim_t s = f_nop(); s.hl = 1; s.rw = 1; s.wa = 5'd22; return s;
  endfunction
  function automatic stim_t f_rand();
    stim_t s;
    s.hold  = ($urandom % 10) == 0;
    s.valid = ($urandom % 10) != 0;
    s.rs    = 5'($urandom_range(0, 3));
    s.rt    = 5'($urandom_range(0, 3));
    s.wa    = 5'($urandom_range(0, 3));
    s.pc    = 2'($urandom_range(0, 3));
    s.br    = ($urandom % 5) == 0;
    s.eq    = 1'($urandom % 2);
    s.rw    = ($urandom % 10) < 6;
    s.mr    = ($urandom % 10) < 3;
    s.md    = ($urandom % 40) == 0;
    s.hl    = ($urandom % 10) == 0;
    return s;
  endfunction
  function automatic vec_t mkv(string n, stim_t s, logic dh, logic ch, logic busy);
    vec_t v; v.name = n; v.s = s; v.dh = dh; v.ch = ch; v.busy = busy; return v;
  endfunction

  // ---------------- reference model ----------------
  // A write is visible for DEPTH unheld cycles after issue; it still blocks
  // an ID consumer while lat-age > 0 and an EX consumer while lat-age > 1.
  function automatic logic m_gpr(stim_t s);
    logic ic = s.br || (s.pc == 2'b10);
    foreach (wr_q[i]) begin
      int age = tick - wr_q[i].born;
      int rem = wr_q[i].lat - age;
      if (age < DEPTH && wr_q[i].addr != 0 &&
          (wr_q[i].addr == s.rs || wr_q[i].addr == s.rt) &&
          (ic ? rem > 0 : rem > 1))
        return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic logic m_dh(stim_t s);
    return s.valid && (m_gpr(s) || ((s.md || s.hl) && md_rem != 0));
  endfunction
  function automatic logic m_ch(stim_t s);
    return s.valid && (s.pc == 2'b01 ||
                       (!m_dh(s) && (s.pc == 2'b10 || (s.br && s.eq))));
  endfunction
  task automatic m_step(input stim_t s);
    logic issue = s.valid && !m_dh(s) && !s.hold;
    if (!s.hold) begin
      tick++;
      if (issue && s.rw && s.wa != 0) begin
        wr_t w;
        w.addr = s.wa; w.lat = s.mr ? LOAD_LAT : ALU_LAT; w.born = tick;
        wr_q.push_back(w);
      end
      while (wr_q.size() > 0 && tick - wr_q[0].born >= DEPTH) void'(wr_q.pop_front());
    end
    if (issue && s.md) md_rem = MD_CYCLES;
    else if (md_rem > 0) md_rem--;
  endtask
  task automatic m_clear();
    wr_q.delete(); tick = 0; md_rem = 0;
  endtask

  // ---------------- drive / check ----------------
  task automatic drive(input stim_t s);
    bus.pipe_hold     = s.hold;
    bus.id_valid      = s.valid;
    bus.id_rs_addr    = s.rs;
    bus.id_rt_addr    = s.rt;
    bus.id_PCSrc      = s.pc;
    bus.id_Branch     = s.br;
    bus.id_Equal      = s.eq;
    bus.id_RegWrite   = s.rw;
    bus.id_MemRead    = s.mr;
    bus.id_write_addr = s.wa;
    bus.id_MulDiv     = s.md;
    bus.id_HiLoRead   = s.hl;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply s after the edge, sample mid-cycle, advance the model.
  task automatic cycle(input stim_t s, output logic dh, output logic ch, output logic busy,
                       output logic edh, output logic ech, output logic ebusy);
    @(posedge clk); #1;
    drive(s);
    @(negedge clk);
    dh = bus.DataHazard; ch = bus.ControlHazard; busy = bus.md_busy;
    edh = m_dh(s); ech = m_ch(s); ebusy = (md_rem != 0);
    m_step(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(f_idle());
    m_clear();
    @(negedge clk);
    chk("reset_dh", bus.DataHazard, 1'b0);
    chk("reset_busy", bus.md_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    logic dh, ch, busy, edh, ech, ebusy;
    drive(f_idle());

    tbl.push_back(mkv("idle_after_reset", f_idle(),               0, 0, 0));
    tbl.push_back(mkv("lw8_issue",        f_lw(8, 1),             0, 0, 0));
    tbl.push_back(mkv("add_use8_stall",   f_alu(3, 8, 2),         1, 0, 0));
    tbl.push_back(mkv("add_use8_go",      f_alu(3, 8, 2),         0, 0, 0));
    tbl.push_back(mkv("nop_a",            f_nop(),                0, 0, 0));
    tbl.push_back(mkv("add9_issue",       f_alu(9, 4, 5),         0, 0, 0));
    tbl.push_back(mkv("beq9_stall",       f_beq(9, 0, 1),         1, 0, 0));
    tbl.push_back(mkv("beq9_taken",       f_beq(9, 0, 1),         0, 1, 0));
    tbl.push_back(mkv("add11_issue",      f_alu(11, 6, 7),        0, 0, 0));
    tbl.push_back(mkv("add_use11_nostall",f_alu(12, 11, 0),       0, 0, 0));
    tbl.push_back(mkv("lw10_issue",       f_lw(10, 1),            0, 0, 0));
    tbl.push_back(mkv("nop_b",            f_nop(),                0, 0, 0));
    tbl.push_back(mkv("beq_rt10_stall",   f_beq(0, 10, 0),        1, 0, 0));
    tbl.push_back(mkv("beq_rt10_go",      f_beq(0, 10, 0),        0, 0, 0));
    tbl.push_back(mkv("lw_r0",            f_lw(0, 1),             0, 0, 0));
    tbl.push_back(mkv("beq_r0_use",       f_beq(0, 0, 1),         0, 1, 0));
    tbl.push_back(mkv("lw13_issue",       f_lw(13, 1),            0, 0, 0));
    tbl.push_back(mkv("j_with_hazard",    f_j(13),                1, 1, 0));
    tbl.push_back(mkv("j_clear",          f_j(13),                0, 1, 0));
    tbl.push_back(mkv("lw14_issue",       f_lw(14, 1),            0, 0, 0));
    tbl.push_back(mkv("beq14_stall_a",    f_beq(14, 0, 1),        1, 0, 0));
    tbl.push_back(mkv("beq14_stall_b",    f_beq(14, 0, 1),        1, 0, 0));
    tbl.push_back(mkv("beq14_taken",      f_beq(14, 0, 1),        0, 1, 0));
    tbl.push_back(mkv("add15_issue",      f_alu(15, 1, 2),        0, 0, 0));
    tbl.push_back(mkv("jr15_stall",       f_jr(15),               1, 0, 0));
    tbl.push_back(mkv("jr15_go",          f_jr(15),               0, 1, 0));

    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].s, dh, ch, busy, edh, ech, ebusy);
      chk({tbl[i].name, "_dh"},   dh,   tbl[i].dh);
      chk({tbl[i].name, "_ch"},   ch,   tbl[i].ch);
      chk({tbl[i].name, "_busy"}, busy, tbl[i].busy);
    end

    // mult then mflo: mflo held for exactly MD_CYCLES cycles
    cycle(f_mult(), dh, ch, busy, edh, ech, ebusy);
    chk("mult_issue_dh", dh, 1'b0);
    for (int i = 0; i < MD_CYCLES; i++) begin
      cycle(f_mflo(), dh, ch, busy, edh, ech, ebusy);
      chk($sformatf("mflo_wait%0d_dh", i), dh, 1'b1);
      chk($sformatf("mflo_wait%0d_busy", i), busy, 1'b1);
    end
    cycle(f_mflo(), dh, ch, busy, edh, ech, ebusy);
    chk("mflo_go_dh", dh, 1'b0);
    chk("mflo_go_busy", busy, 1'b0);

    // pipe_hold after lw: scoreboard frozen, hazard persists
    cycle(f_lw(16, 1), dh, ch, busy, edh, ech, ebusy);
    chk("lw16_issue_dh", dh, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stim_t s = f_alu(18, 16, 0);
      s.hold = 1;
      cycle(s, dh, ch, busy, edh, ech, ebusy);
      chk($sformatf("hold%0d_dh", i), dh, 1'b1);
    end
    cycle(f_alu(18, 16, 0), dh, ch, busy, edh, ech, ebusy);
    chk("unhold_still_dh", dh, 1'b1);
    cycle(f_alu(18, 16, 0), dh, ch, busy, edh, ech, ebusy);
    chk("unhold_clear_dh", dh, 1'b0);

    // asynchronous reset mid-run
    cycle(f_mult(), dh, ch, busy, edh, ech, ebusy);
    cycle(f_lw(17, 1), dh, ch, busy, edh, ech, ebusy);
    chk("pre_rst_busy", busy, 1'b1);
    cycle(f_alu(18, 17, 0), dh, ch, busy, edh, ech, ebusy);
    chk("pre_rst_dh", dh, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_dh", bus.DataHazard, 1'b0);
    chk("mid_rst_busy", bus.md_busy, 1'b0);
    m_clear();
    @(negedge clk);
    reset = 1'b1;
    cycle(f_alu(18, 17, 0), dh, ch, busy, edh, ech, ebusy);
    chk("post_rst_dh", dh, 1'b0);
    chk("post_rst_busy", busy, 1'b0);

    // random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle(f_rand(), dh, ch, busy, edh, ech, ebusy);
      chk($sformatf("rnd%0d_dh", i),   dh,   edh);
      chk($sformatf("rnd%0d_ch", i),   ch,   ech);
      chk($sformatf("rnd%0d_busy", i), busy, ebusy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
